// File: rtl/opmode_seq.sv
// opmode_seq: table-driven sequencer feeding OPMODE, CE and sync-reset of a downstream OPMODE register.
// Plays {OPMODE, REPEAT} steps after START, clears the register first, and flushes it on ABORT.
module opmode_seq #(
    parameter  int DEPTH = 8,
    parameter  int CNT_W = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [6:0]       wr_opmode_i,
    input  logic [CNT_W-1:0] wr_repeat_i,
    input  logic [AW-1:0]    last_idx_i,
    input  logic             start_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [AW-1:0]    step_idx_o,
    output logic [6:0]       opmode_o,
    output logic             cectrl_o,
    output logic             rstctrl_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [AW-1:0]    IDX0 = {AW{1'b0}};
    localparam logic [CNT_W-1:0] CNT0 = {CNT_W{1'b0}};

    state_e           state_q, state_d;
    logic [AW-1:0]    last_q, last_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ce_q, ce_d;
    logic             rstc_q, rstc_d;
    logic [AW-1:0]    step_q, step_d;
    logic [6:0]       op_q, op_d;
    logic [AW-1:0]    idx_nx_s;

    logic [6:0]       tbl_op_q  [DEPTH];
    logic [CNT_W-1:0] tbl_rep_q [DEPTH];

    assign idx_nx_s = idx_q + AW'(1'b1);

    // Step table: writable only while idle so a running sequence never sees it change.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_op_q[i]  <= 7'd0;
                tbl_rep_q[i] <= CNT0;
            end
        end else if (wr_en_i && (state_q == ST_IDLE)) begin
            tbl_op_q[wr_addr_i]  <= wr_opmode_i;
            tbl_rep_q[wr_addr_i] <= wr_repeat_i;
        end
    end

    // Next state and next output values; outputs describe the state being entered.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ce_d    = ce_q;
        rstc_d  = rstc_q;
        step_d  = step_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_CLR;
                    last_d  = last_idx_i;
                    idx_d   = IDX0;
                    cnt_d   = CNT0;
                    busy_d  = 1'b1;
                    ce_d    = 1'b1;
                    rstc_d  = 1'b1;
                    step_d  = IDX0;
                    op_d    = 7'd0;
                end else begin
                    busy_d = 1'b0;
                    ce_d   = 1'b0;
                    rstc_d = 1'b0;
                    step_d = IDX0;
                    op_d   = 7'd0;
                end
            end
            ST_CLR, ST_RUN: begin
                if (abort_i) begin
                    state_d = ST_FLUSH;
                    idx_d   = IDX0;
                    cnt_d   = CNT0;
                    busy_d  = 1'b1;
                    ce_d    = 1'b1;
                    rstc_d  = 1'b1;
                    step_d  = IDX0;
                    op_d    = 7'd0;
                end else if (state_q == ST_CLR) begin
                    state_d = ST_RUN;
                    idx_d   = IDX0;
                    cnt_d   = CNT0;
                    busy_d  = 1'b1;
                    ce_d    = 1'b1;
                    rstc_d  = 1'b0;
                    step_d  = IDX0;
                    op_d    = tbl_op_q[IDX0];
                end else if (cnt_q != tbl_rep_q[idx_q]) begin
                    cnt_d = cnt_q + CNT_W'(1'b1);
                end else if (idx_q != last_q) begin
                    idx_d  = idx_nx_s;
                    cnt_d  = CNT0;
                    step_d = idx_nx_s;
                    op_d   = tbl_op_q[idx_nx_s];
                end else begin
                    // Final step complete: OPMODE and STEP_IDX hold through the DONE cycle.
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    ce_d    = 1'b0;
                    rstc_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = IDX0;
                cnt_d   = CNT0;
                busy_d  = 1'b0;
                ce_d    = 1'b0;
                rstc_d  = 1'b0;
                step_d  = IDX0;
                op_d    = 7'd0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            last_q  <= IDX0;
            idx_q   <= IDX0;
            cnt_q   <= CNT0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ce_q    <= 1'b0;
            rstc_q  <= 1'b0;
            step_q  <= IDX0;
            op_q    <= 7'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ce_q    <= ce_d;
            rstc_q  <= rstc_d;
            step_q  <= step_d;
            op_q    <= op_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign step_idx_o = step_q;
    assign opmode_o   = op_q;
    assign cectrl_o   = ce_q;
    assign rstctrl_o  = rstc_q;

endmodule
